// File: rtl/temp_rgb_pwm_pkg.sv
// Shared band encoding and duty clamp for the temperature-to-RGB LED driver.
package temp_led_pkg;

    localparam logic [1:0] BAND_IDLE = 2'd0;
    localparam logic [1:0] BAND_COLD = 2'd1;
    localparam logic [1:0] BAND_WARM = 2'd2;
    localparam logic [1:0] BAND_HOT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = BAND_IDLE,
        ST_COLD = BAND_COLD,
        ST_WARM = BAND_WARM,
        ST_HOT  = BAND_HOT
    } band_t;

    // Clamp to the largest value a width-bit duty can hold instead of wrapping.
    function automatic logic [31:0] sat_duty(input logic [31:0] val, input int unsigned width);
        logic [31:0] mx;
        mx = (32'd1 << width) - 32'd1;
        return (val > mx) ? mx : val;
    endfunction

endpackage

// File: rtl/temp_rgb_pwm_pwm_gen.sv
// Free-running PWM counter with a duty shadow register that only reloads on wrap.
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_nxt,
    output logic             wrap,
    output logic             pwm_on
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_act;

    assign wrap   = (cnt == '1);
    assign pwm_on = (cnt < duty_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            duty_act <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
            // Reloading only at the period boundary keeps each period glitch-free.
            if (wrap)
                duty_act <= duty_nxt;
        end
    end

endmodule

// File: rtl/temp_rgb_pwm.sv
// Temperature reading -> hysteretic colour band -> PWM-dimmed LED bank.
// Optional: TEMP_LED_HOT_BLINK_EN adds a slow blink on the red bank while HOT.
import temp_led_pkg::*;

module temp_rgb_pwm #(
    parameter int VAL_W   = 9,
    parameter int LED_N   = 8,
    parameter int PWM_W   = 8,
    parameter int COLD_TH = 10,
    parameter int HOT_TH  = 30,
    parameter int HYST    = 2,
    parameter int BLINK_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [VAL_W-1:0] value,
    output logic [LED_N-1:0] LEDSR,
    output logic [LED_N-1:0] LEDSG,
    output logic [LED_N-1:0] LEDSB,
    output logic [1:0]       band
);

    localparam logic [VAL_W-1:0] COLD_LO = VAL_W'(COLD_TH);
    localparam logic [VAL_W-1:0] COLD_UP = VAL_W'(COLD_TH + HYST);
    localparam logic [VAL_W-1:0] HOT_LO  = VAL_W'(HOT_TH);
    localparam logic [VAL_W-1:0] HOT_UP  = VAL_W'(HOT_TH + HYST);

    band_t            state, state_nxt;
    logic [VAL_W-1:0] val_q;
    logic [PWM_W-1:0] duty_nxt;
    logic             wrap, pwm_on, hot_gate;

    assign band     = state;
    assign duty_nxt = PWM_W'(sat_duty(32'(val_q), PWM_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            val_q <= '0;
        end else begin
            state <= state_nxt;
            if (sample_valid)
                val_q <= value;
        end
    end

    // Upward crossings need the extra HYST margin; downward ones switch at the threshold.
    always_comb begin
        state_nxt = state;
        if (sample_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (value < COLD_LO)     state_nxt = ST_COLD;
                    else if (value < HOT_LO) state_nxt = ST_WARM;
                    else                     state_nxt = ST_HOT;
                end
                ST_COLD: begin
                    if (value >= HOT_UP)       state_nxt = ST_HOT;
                    else if (value >= COLD_UP) state_nxt = ST_WARM;
                end
                ST_WARM: begin
                    if (value < COLD_LO)      state_nxt = ST_COLD;
                    else if (value >= HOT_UP) state_nxt = ST_HOT;
                end
                ST_HOT: begin
                    if (value < COLD_LO)     state_nxt = ST_COLD;
                    else if (value < HOT_LO) state_nxt = ST_WARM;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    pwm_gen #(.PWM_W(PWM_W)) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_nxt (duty_nxt),
        .wrap     (wrap),
        .pwm_on   (pwm_on)
    );

`ifdef TEMP_LED_HOT_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_q;

    // Restart lit on every entry to HOT so the first blink phase is always visible.
    always_ff @(posedge clk) begin
        if (rst || (state != ST_HOT && state_nxt == ST_HOT)) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (wrap) begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
            if (blink_cnt == '1)
                blink_q <= ~blink_q;
        end
    end

    assign hot_gate = blink_q;
`else
    assign hot_gate = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            LEDSR <= '0;
            LEDSG <= '0;
            LEDSB <= '0;
        end else begin
            LEDSR <= '0;
            LEDSG <= '0;
            LEDSB <= '0;
            unique case (state)
                ST_COLD: LEDSB <= {LED_N{pwm_on}};
                ST_WARM: LEDSG <= {LED_N{pwm_on}};
                ST_HOT:  LEDSR <= {LED_N{pwm_on & hot_gate}};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_rgb_pwm.sv
// Random and directed samples against a time-based reference model, scoreboarded per cycle.
module tb_temp_rgb_pwm;

    localparam int COLD_TH = 10;
    localparam int HOT_TH  = 30;
    localparam int HYST    = 2;
    localparam int PERIOD  = 256;
    localparam int BW      = 1;

    typedef struct packed {
        logic [1:0] band;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [8:0] value = '0;
    logic [7:0] LEDSR, LEDSG, LEDSB;
    logic [1:0] band;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit drv_done = 1'b0;
    exp_t sb[$];

    // Reference state: cycles into the current period, latched reading, duty in force,
    // band, and wraps seen since the last HOT entry.
    int   m_t = 0, m_val = 0, m_duty = 0, m_band = 0, m_wraps = 0;
    exp_t m_out = '0;

    temp_rgb_pwm #(.BLINK_W(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .value        (value),
        .LEDSR        (LEDSR),
        .LEDSG        (LEDSG),
        .LEDSB        (LEDSB),
        .band         (band)
    );

    always #5 clk = ~clk;

    function automatic int band_rule(int b, int v);
        case (b)
            0:       return (v < COLD_TH) ? 1 : (v < HOT_TH) ? 2 : 3;
            1:       return (v >= HOT_TH + HYST) ? 3 : (v >= COLD_TH + HYST) ? 2 : 1;
            2:       return (v < COLD_TH) ? 1 : (v >= HOT_TH + HYST) ? 3 : 2;
            default: return (v < COLD_TH) ? 1 : (v < HOT_TH) ? 2 : 3;
        endcase
    endfunction

    // Advance the model across one clock edge with the given inputs, and queue the
    // outputs the DUT should show after that edge.
    task automatic step(input bit r, input bit sv, input int v);
        bit lit;
        int nb;
        @(negedge clk);
        rst = r;
        sample_valid = sv;
        value = 9'(v);
        if (r) begin
            m_t = 0; m_val = 0; m_duty = 0; m_band = 0; m_wraps = 0;
            m_out = '0;
        end else begin
            lit = (m_t < m_duty);
`ifdef TEMP_LED_HOT_BLINK_EN
            if (m_band == 3 && ((m_wraps >> BW) & 1) == 1) lit = 1'b0;
`endif
            m_out.band = 2'(m_band);
            m_out.r = (m_band == 3 && lit) ? 8'hFF : 8'h00;
            m_out.g = (m_band == 2 && lit) ? 8'hFF : 8'h00;
            m_out.b = (m_band == 1 && lit) ? 8'hFF : 8'h00;
            if (m_t == PERIOD - 1) begin
                m_duty = (m_val > PERIOD - 1) ? PERIOD - 1 : m_val;
                m_wraps++;
            end
            m_t = (m_t + 1) % PERIOD;
            if (sv) begin
                nb = band_rule(m_band, v);
                if (nb == 3 && m_band != 3) m_wraps = 0;
                m_band = nb;
                m_val = v;
            end
            m_out.band = 2'(m_band);
        end
        sb.push_back(m_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic sample(input int v);
        step(1'b0, 1'b1, v);
    endtask

    task automatic wait_phase(input int t);
        while (m_t != t) step(1'b0, 1'b0, 0);
    endtask

    // Monitor: every clock the DUT presents a full output word; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (band !== e.band || LEDSR !== e.r || LEDSG !== e.g || LEDSB !== e.b) begin
                    bad++;
                    $display("FAIL out@cyc%0d: got band=%0d R=%h G=%h B=%h want band=%0d R=%h G=%h B=%h",
                             cyc, band, LEDSR, LEDSG, LEDSB, e.band, e.r, e.g, e.b);
                end
            end
        end
    end

    initial begin
        int gap;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        idle(2 * PERIOD + 10);
        sample(5);
        idle(2 * PERIOD + 20);
        sample(10);
        idle(PERIOD + 5);
        sample(12);
        idle(2 * PERIOD);
        sample(9);
        idle(PERIOD + 30);
        sample(31);
        idle(PERIOD);
        sample(300);
        idle(3 * PERIOD);
        sample(29);
        idle(PERIOD);
        sample(0);
        idle(2 * PERIOD);
        sample(20);
        idle(PERIOD + 10);
        wait_phase(PERIOD - 1);
        sample(40);
        idle(2 * PERIOD + 10);
        sample(255);
        idle(PERIOD);
        sample(32);
        idle(5 * PERIOD);
        wait_phase(100);
        step(1'b1, 1'b0, 0);
        idle(PERIOD + 50);
        sample(60);
        idle(2 * PERIOD);
        for (int k = 0; k < 30; k++) begin
            gap = $urandom_range(1, 700);
            idle(gap);
            if ($urandom_range(0, 15) == 0) step(1'b1, 1'b0, 0);
            else sample($urandom_range(0, 350));
        end
        idle(2 * PERIOD);
        drv_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!drv_done && guard < 90000) begin
            @(posedge clk);
            guard++;
        end
        if (!drv_done) begin
            bad++;
            $display("FAIL timeout: driver still running after %0d cycles, required completion", guard);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_rgb_pwm.md
Name: temp_rgb_pwm

Overview:
- Maps a periodically sampled temperature reading (LM35 → ADC → number path) onto three 8-LED colour banks: blue = cold, green = warm, red = hot.
- Colour band is chosen by a hysteretic state machine.
- LED brightness is PWM-modulated in proportion to the reading, with a saturating duty.
- Sits between the temperature-number datapath and the board LED pins.

Parameters:
- VAL_W, 9, width of the temperature value.
- LED_N, 8, LEDs per colour bank.
- PWM_W, 8, PWM counter/duty width; period = 2^PWM_W clocks.
- COLD_TH, 10, cold/warm boundary.
- HOT_TH, 30, warm/hot boundary (must exceed COLD_TH+HYST).
- HYST, 2, upward-crossing hysteresis margin.
- BLINK_W, 6, blink toggles every 2^BLINK_W PWM periods (optional feature only).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- sample_valid, in, 1, single-cycle strobe; value is valid this cycle.
- value, in, VAL_W, unsigned temperature reading.
- LEDSR, out, LED_N, red bank.
- LEDSG, out, LED_N, green bank.
- LEDSB, out, LED_N, blue bank.
- band, out, 2, current state: 0 IDLE, 1 COLD, 2 WARM, 3 HOT.

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - Reset clears val_q, PWM counter, duty_act, band (→IDLE), blink state, and all LED outputs to 0.
  - A reset mid-period aborts the period; the first post-reset period begins the cycle after rst deasserts.
- Sample capture:
  - On sample_valid, val_q ← value.
  - Band FSM evaluates the same value in that cycle; band updates on the next edge (latency 1).
- Band FSM:
  - IDLE → classify the first sample directly: value < COLD_TH → COLD; value < HOT_TH → WARM; else HOT.
  - COLD → WARM when value ≥ COLD_TH+HYST.
  - COLD → HOT when value ≥ HOT_TH+HYST.
  - WARM → COLD when value < COLD_TH.
  - WARM → HOT when value ≥ HOT_TH+HYST.
  - HOT → WARM when COLD_TH ≤ value < HOT_TH.
  - HOT → COLD when value < COLD_TH.
  - Otherwise hold. No transition without sample_valid.
  - Values inside the hysteresis window (e.g. 10–11 from COLD) hold the current band.
- Duty:
  - duty_nxt = min(val_q, 2^PWM_W−1); saturate, never truncate (value 300 → 255).
  - duty_act ← duty_nxt only on the counter wrap cycle (cnt = 2^PWM_W−1), so there are no mid-period glitches.
  - A sample arriving on the wrap cycle takes effect one period later.
- PWM:
  - cnt is free-running PWM_W bits and wraps to 0.
  - pwm_on = (cnt < duty_act).
  - duty 0 → never on; duty 255 → on 255 of 256 clocks.
- Outputs (registered, 1 clock after cnt):
  - Active bank = {LED_N{pwm_on}}; the other two banks are 0.
  - COLD → LEDSB, WARM → LEDSG, HOT → LEDSR.
  - IDLE → all banks 0.
  - Exactly one bank is ever nonzero.
- band output is the FSM state register directly.

Optional Feature:
- Macro: TEMP_LED_HOT_BLINK_EN.
- Defined:
  - In HOT, LEDSR is additionally gated by blink_q.
  - blink_q toggles every 2^BLINK_W counter wraps.
  - The blink counter resets to 0 and blink_q resets to 1 on rst and on entry to HOT.
- Undefined:
  - HOT drives a steady PWM.
  - No blink logic is synthesised and BLINK_W is unused.

Decomposition:
- Package temp_led_pkg:
  - Band encoding localparams: BAND_IDLE/COLD/WARM/HOT.
  - Saturating-clamp function sat_duty(val, width).
- Sub-module pwm_gen (params PWM_W):
  - Counter, shadow duty register, wrap strobe, pwm_on.
  - Exports wrap for the blink counter.
- Band FSM and output mux stay in the top.

Test Plan:
- Reset held 3 clocks, then no samples → band=0, all LEDs 0 for ≥2 PWM periods.
- Sample 5 → band=1 next clock; after the next wrap, LEDSB=0xFF for exactly 5 of 256 clocks and LEDSR=LEDSG=0.
- Hysteresis, starting COLD: sample 10 → band stays 1; sample 12 → band=2 with LEDSG active; sample 9 → band=1.
- Saturation: sample 300 → band=3; after wrap, LEDSR=0xFF for 255 of 256 clocks. Sample 0 in COLD → LEDSB stays 0 all period.
- Sample at wrap: duty 20 running, sample 40 on the wrap cycle → next period high 20 clocks, following period 40. Assert rst mid-period → outputs 0 the following clock and cnt restarts at 0.
- Blink, TEMP_LED_HOT_BLINK_EN defined, BLINK_W=1 → in HOT, LEDSR pulses for 2 periods then is dark for 2 periods. Macro undefined → steady pulses.
